// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared FSM states, key map and LFSR constants for the keypad emulator
package keypad_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS_BNC,
        ST_HOLD,
        ST_REL_BNC,
        ST_GAP
    } state_e;

    // Nibble k holds {row, col} of hex key k. Layout:
    // row0 = 1 2 3 A, row1 = 4 5 6 B, row2 = 7 8 9 C, row3 = E 0 F D.
    localparam logic [63:0] KEY_MAP = {
        4'hE, 4'hC, 4'hF, 4'hB,   // keys F E D C
        4'h7, 4'h3, 4'hA, 4'h9,   // keys B A 9 8
        4'h8, 4'h6, 4'h5, 4'h4,   // keys 7 6 5 4
        4'h2, 4'h1, 4'h0, 4'hD    // keys 3 2 1 0
    };

    // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3.
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [3:0] key_pos(input logic [3:0] key);
        return KEY_MAP[{key, 2'b00} +: 4];
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bounce_lfsr.sv
// rtl/bounce_lfsr.sv - 8-bit Fibonacci LFSR producing the contact-bounce pattern
module bounce_lfsr
    import keypad_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic bounce
);

    logic [7:0] lfsr_q;

    // Shift only while enabled so every bounce window continues the same sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else if (enable) begin
            lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    assign bounce = lfsr_q[0];

endmodule

// File: rtl/keypad_emulator.sv
// rtl/keypad_emulator.sv - matrix keypad press emulator; KEYPAD_EMU_BOUNCE_EN adds contact bounce
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int HOLD_W        = 16,
    parameter int BOUNCE_CYCLES = 8,
    parameter int GAP_CYCLES    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_key,
    input  logic [HOLD_W-1:0] cmd_hold,
    input  logic [3:0]        col_n,
    output logic [3:0]        row_n,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = max_int(HOLD_W,
                           max_int($clog2(BOUNCE_CYCLES + 1), $clog2(GAP_CYCLES + 1)));
    localparam logic [CNT_W-1:0] BNC_LAST = CNT_W'(BOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        row_q, col_q;
    logic [HOLD_W-1:0] hold_m1_q;
    logic [3:0]        pos;
    logic              accept;
    logic              contact;

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = ~cmd_ready;
    assign accept    = cmd_valid & cmd_ready;
    assign pos       = key_pos(cmd_key);

    // State, phase counter and the latched command; hold is kept as count-1 so 0 maps to 1 cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            row_q     <= '0;
            col_q     <= '0;
            hold_m1_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                row_q     <= pos[3:2];
                col_q     <= pos[1:0];
                hold_m1_q <= (cmd_hold == '0) ? '0 : cmd_hold - 1'b1;
            end
        end
    end

    // Next-state sequencing through the press phases; done marks the last GAP cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (accept) begin
`ifdef KEYPAD_EMU_BOUNCE_EN
                    state_d = ST_PRESS_BNC;
`else
                    state_d = ST_HOLD;
`endif
                end
            end
            ST_PRESS_BNC: begin
                if (cnt_q == BNC_LAST) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            end
            ST_HOLD: begin
                if (cnt_q == CNT_W'(hold_m1_q)) begin
`ifdef KEYPAD_EMU_BOUNCE_EN
                    state_d = ST_REL_BNC;
`else
                    state_d = ST_GAP;
`endif
                    cnt_d   = '0;
                end
            end
            ST_REL_BNC: begin
                if (cnt_q == BNC_LAST) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done    = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef KEYPAD_EMU_BOUNCE_EN
    logic bounce_bit;

    bounce_lfsr u_bounce_lfsr (
        .clk    (clk),
        .rst    (rst),
        .enable ((state_q == ST_PRESS_BNC) || (state_q == ST_REL_BNC)),
        .bounce (bounce_bit)
    );

    // Contact is closed in HOLD and chatters with the LFSR in the bounce phases.
    always_comb begin
        contact = (state_q == ST_HOLD);
        if ((state_q == ST_PRESS_BNC) || (state_q == ST_REL_BNC)) begin
            contact = bounce_bit;
        end
    end
`else
    // Clean contact: closed only while holding.
    always_comb begin
        contact = (state_q == ST_HOLD);
    end
`endif

    // Passive switch: the latched row follows its column drive with no register in between.
    always_comb begin
        row_n = 4'hF;
        if (contact && !col_n[col_q]) begin
            row_n[row_q] = 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_emulator.sv
// tb/tb_keypad_emulator.sv - self-checking bench for keypad_emulator
module tb_keypad_emulator;

`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam int B = 8;
`else
    localparam int B = 0;
`endif
    localparam int GAP = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_key;
    logic [15:0] cmd_hold;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic        busy;
    logic        done;

    keypad_emulator #(
        .HOLD_W        (16),
        .BOUNCE_CYCLES (8),
        .GAP_CYCLES    (GAP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_key   (cmd_key),
        .cmd_hold  (cmd_hold),
        .col_n     (col_n),
        .row_n     (row_n),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    int done_q[$];
    logic [7:0] mlfsr;
    logic [3:0] km [4][4];
    logic [3:0] gate_pats [4];

    typedef struct {
        logic [3:0] key;
        int         hold;
        logic [3:0] col;
        logic [3:0] closed_row;
    } vec_t;
    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp_v, cyc);
    endtask

    function automatic int eff(input int h);
        return (h == 0) ? 1 : h;
    endfunction

    task automatic locate(input logic [3:0] key, output int r, output int c);
        r = 0;
        c = 0;
        for (int rr = 0; rr < 4; rr++)
            for (int cc = 0; cc < 4; cc++)
                if (km[rr][cc] == key) begin
                    r = rr;
                    c = cc;
                end
    endtask

    task automatic bounce_bit(output logic b);
        b = mlfsr[0];
        mlfsr = {mlfsr[6:0], mlfsr[7] ^ mlfsr[5] ^ mlfsr[4] ^ mlfsr[3]};
    endtask

    // Done scoreboard: each accepted command pushed its expected done cycle.
    always @(negedge clk) begin
        if (done) begin
            if (done_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
            else check("done_cycle", cyc, done_q.pop_front());
        end
    end

    task automatic issue(input logic [3:0] key, input int hold, output int acc);
        bit ok;
        ok = 0;
        cmd_key   = key;
        cmd_hold  = hold[15:0];
        cmd_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                @(posedge clk);
                #1;
                ok = 1;
            end
        end
        acc = cyc;
        cmd_valid = 1'b0;
        check("accept_timeout", {31'd0, ok}, 32'd1);
        if (ok) done_q.push_back(acc + 2 * B + eff(hold) + GAP - 1);
    endtask

    task automatic check_window(input logic [3:0] key, input int hold, input logic [3:0] closed,
                                input bit gate, input int ncyc);
        int r, c, h, tot;
        logic ct;
        logic [3:0] exp_row;
        locate(key, r, c);
        h = eff(hold);
        tot = 2 * B + h + GAP;
        if (ncyc < tot) tot = ncyc;
        for (int i = 0; i < tot; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            if (i < B || (i >= B + h && i < 2 * B + h)) bounce_bit(ct);
            else ct = (i >= B && i < B + h);
            if (gate) begin
                if (i >= B && i < B + h) begin
                    col_n = gate_pats[i % 4];
                    #1;
                end
                exp_row = 4'hF;
                if (ct && !col_n[c]) exp_row[r] = 1'b0;
            end else begin
                exp_row = ct ? closed : 4'hF;
            end
            check("row_n", {28'd0, row_n}, {28'd0, exp_row});
            check("busy", {31'd0, busy}, 32'd1);
        end
    endtask

    task automatic tail_idle();
        @(posedge clk);
        #1;
        check("ready_after_done", {31'd0, cmd_ready}, 32'd1);
        check("idle_not_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int acc, acc2;
        km[0] = '{4'h1, 4'h2, 4'h3, 4'hA};
        km[1] = '{4'h4, 4'h5, 4'h6, 4'hB};
        km[2] = '{4'h7, 4'h8, 4'h9, 4'hC};
        km[3] = '{4'hE, 4'h0, 4'hF, 4'hD};
        gate_pats = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        vecs[0] = '{4'h5, 10, 4'b1101, 4'b1101};
        vecs[1] = '{4'hD,  3, 4'b0111, 4'b0111};
        vecs[2] = '{4'h0,  0, 4'b1101, 4'b0111};
        vecs[3] = '{4'hA,  4, 4'b1110, 4'b1111};
        vecs[4] = '{4'h7,  5, 4'b0000, 4'b1011};
        vecs[5] = '{4'hE,  2, 4'b1110, 4'b0111};
        vecs[6] = '{4'hC,  6, 4'b0110, 4'b1011};
        vecs[7] = '{4'h9,  1, 4'b1011, 4'b1011};

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_key = 4'h0;
        cmd_hold = 16'd0;
        col_n = 4'h0;
        mlfsr = 8'hA5;
        repeat (3) @(posedge clk);
        #1;
        check("reset_row_n", {28'd0, row_n}, 32'hF);
        check("reset_ready", {31'd0, cmd_ready}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        rst = 1'b0;

        for (int v = 0; v < 8; v++) begin
            col_n = vecs[v].col;
            issue(vecs[v].key, vecs[v].hold, acc);
            check_window(vecs[v].key, vecs[v].hold, vecs[v].closed_row, 1'b0, 1000);
            tail_idle();
        end

        // Column gating while key D is held.
        col_n = 4'hF;
        issue(4'hD, 12, acc);
        check_window(4'hD, 12, 4'hF, 1'b1, 1000);
        tail_idle();

        // Handshake: valid stays high, second key waits until the cycle after done.
        col_n = 4'b1101;
        cmd_key = 4'h2;
        cmd_hold = 16'd2;
        cmd_valid = 1'b1;
        @(negedge clk);
        check("hs_ready", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
        done_q.push_back(cyc + 2 * B + 2 + GAP - 1);
        cmd_key = 4'h3;
        check_window(4'h2, 2, 4'b1110, 1'b0, 1000);
        @(posedge clk);
        #1;
        check("hs_ready_after_done", {31'd0, cmd_ready}, 32'd1);
        col_n = 4'b1011;
        acc2 = cyc + 1;
        done_q.push_back(acc2 + 2 * B + 2 + GAP - 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("hs_second_accepted", {31'd0, busy}, 32'd1);
        check_window(4'h3, 2, 4'b1110, 1'b0, 1000);
        tail_idle();

        // Reset in the middle of HOLD aborts without done.
        col_n = 4'b1101;
        issue(4'h5, 50, acc);
        check_window(4'h5, 50, 4'b1101, 1'b0, B + 3);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        col_n = 4'h0;
        done_q.delete();
        mlfsr = 8'hA5;
        check("abort_row_n", {28'd0, row_n}, 32'hF);
        check("abort_ready", {31'd0, cmd_ready}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        repeat (100) @(posedge clk);
        #1;
        check("abort_row_n_late", {28'd0, row_n}, 32'hF);
        check("pending_done", done_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
